// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM state type and EX/MEM payload for the memory stage.
package mem_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [4:0] LINK_REG = 5'd31;

  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned WAIT_CNT_W  = 16;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] answer;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        alink;
    logic [31:0] link_pc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic [1:0]  size;
    logic        uns;
  } exmem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage and the data memory.
interface mem_stage_if;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ack
  );

endinterface

// File: rtl/mem_stage_ls_align.sv
// Load/store lane formatting: store replication and byte enables, load
// lane extraction with sign/zero extension, and misalignment detection.
module ls_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_c,
  output logic [3:0]  be_c,
  output logic [31:0] load_c,
  output logic        misaligned_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    byte_lane = rdata[7:0];
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Size-dependent formatting; unknown size encodings behave as word.
  always_comb begin
    wdata_c      = store_data;
    be_c         = 4'b1111;
    load_c       = rdata;
    misaligned_c = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wdata_c = {4{store_data[7:0]}};
        be_c    = 4'b0001 << offset;
        load_c  = uns ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SIZE_HALF: begin
        wdata_c      = {2{store_data[15:0]}};
        be_c         = offset[1] ? 4'b1100 : 4'b0011;
        load_c       = uns ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
        misaligned_c = offset[0];
      end
      SIZE_WORD: begin
        misaligned_c = |offset;
      end
      default: begin
        misaligned_c = |offset;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, variable-latency data-memory access with
// timeout, load/store formatting, MEM/WB register and EX/MEM forwarding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned LINK_OFS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic [31:0]            ex_answer,
  input  logic [31:0]            ex_store_data,
  input  logic [4:0]             ex_dest,
  input  logic                   ex_alink,
  input  logic [31:0]            ex_link_pc,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic                   ex_memwrite,
  input  logic                   ex_memtoreg,
  input  logic [1:0]             ex_size,
  input  logic                   ex_unsigned,
  output logic                   stall_out,
  mem_stage_if.master            bus,
  output logic [4:0]             exmem_dest,
  output logic                   exmem_regwrite,
  output logic [31:0]            exmem_result,
  output logic                   wb_valid,
  output logic                   wb_regwrite,
  output logic [4:0]             wb_dest,
  output logic [31:0]            wb_data,
  output logic                   misalign,
  output logic                   bus_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_CNT_W-1:0] TMO_LIM = WAIT_CNT_W'(TIMEOUT);

  // Elaboration-time parameter sanity.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT must be in 1..65535");
  end
  if ((LINK_OFS % 4) != 0) begin : g_bad_link_ofs
    $error("mem_stage: LINK_OFS must be a whole number of instructions");
  end

  exmem_t                r;
  exmem_t                ex_in;
  state_t                state;
  logic [WAIT_CNT_W-1:0] wcnt;

  logic        is_mem;
  logic        mis;
  logic        go;
  logic        req;
  logic        tmo;
  logic        stall;
  logic        abort;
  logic [31:0] wdata_c;
  logic [3:0]  be_c;
  logic [31:0] load_c;
  logic [31:0] wb_next;

  ls_align u_align (
    .offset       (r.answer[1:0]),
    .size         (r.size),
    .uns          (r.uns),
    .store_data   (r.store_data),
    .rdata        (bus.dm_rdata),
    .wdata_c      (wdata_c),
    .be_c         (be_c),
    .load_c       (load_c),
    .misaligned_c (mis)
  );

  // Pack the EX-side inputs into the pipeline payload.
  always_comb begin
    ex_in            = '0;
    ex_in.valid      = ex_valid;
    ex_in.answer     = ex_answer;
    ex_in.store_data = ex_store_data;
    ex_in.dest       = ex_dest;
    ex_in.alink      = ex_alink;
    ex_in.link_pc    = ex_link_pc;
    ex_in.regwrite   = ex_regwrite;
    ex_in.memread    = ex_memread;
    ex_in.memwrite   = ex_memwrite;
    ex_in.memtoreg   = ex_memtoreg;
    ex_in.size       = ex_size;
    ex_in.uns        = ex_unsigned;
  end

  // Request, stall and abort decode; an ack in the timeout cycle wins.
  always_comb begin
    is_mem = r.valid & (r.memread | r.memwrite);
    go     = is_mem & ~mis;
    tmo    = (state == WAIT) && (wcnt >= TMO_LIM);
    req    = (state == WAIT) | go;
    stall  = 1'b0;
    abort  = 1'b0;
    case (state)
      RUN:  stall = go & ~bus.dm_ack;
      WAIT: begin
        stall = ~bus.dm_ack & ~tmo;
        abort = ~bus.dm_ack & tmo;
      end
      default: begin
        stall = 1'b0;
        abort = 1'b0;
      end
    endcase
  end

  // Write-back data selection: link address, then load data, then ALU result.
  always_comb begin
    wb_next = r.answer;
    if (r.alink) begin
      wb_next = r.link_pc;
    end else if (r.memtoreg) begin
      wb_next = load_c;
    end
  end

  // Bus drive is derived from the held EX/MEM entry so it stays stable while waiting.
  assign bus.dm_req   = req;
  assign bus.dm_we    = req & r.memwrite;
  assign bus.dm_addr  = req ? {r.answer[31:2], 2'b00} : 32'd0;
  assign bus.dm_wdata = (req & r.memwrite) ? wdata_c : 32'd0;
  assign bus.dm_be    = req ? be_c : 4'd0;
  assign stall_out    = stall;

  // Loads never forward from here; the hazard unit bubbles load-use instead.
  assign exmem_dest     = r.dest;
  assign exmem_regwrite = r.valid & r.regwrite & ~r.memread;
  assign exmem_result   = r.alink ? r.link_pc : r.answer;

  // Access FSM with wait-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (go && !bus.dm_ack) begin
            state <= WAIT;
            wcnt  <= WAIT_CNT_W'(1);
          end
        end
        WAIT: begin
          if (bus.dm_ack || tmo) begin
            state <= RUN;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + WAIT_CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // EX/MEM register advances whenever the stage is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (!stall) begin
      r <= ex_in;
    end
  end

  // MEM/WB register; stall cycles insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_dest     <= 5'd0;
      wb_data     <= 32'd0;
    end else if (stall) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_dest     <= 5'd0;
      wb_data     <= 32'd0;
    end else begin
      wb_valid    <= r.valid;
      wb_regwrite <= r.valid & r.regwrite & ~(is_mem & mis) & ~abort;
      wb_dest     <= r.dest;
      wb_data     <= wb_next;
    end
  end

  // Status: misalign pulse, sticky timeout flag, saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      misalign <= ~stall & is_mem & mis;
      if (abort) begin
        bus_err <= 1'b1;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a behavioural memory-stage model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_answer;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_alink;
  logic [31:0] ex_link_pc;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic        stall_out;
  logic [4:0]  exmem_dest;
  logic        exmem_regwrite;
  logic [31:0] exmem_result;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;
  logic [15:0] stall_cnt;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TMO), .LINK_OFS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_answer      (ex_answer),
    .ex_store_data  (ex_store_data),
    .ex_dest        (ex_dest),
    .ex_alink       (ex_alink),
    .ex_link_pc     (ex_link_pc),
    .ex_regwrite    (ex_regwrite),
    .ex_memread     (ex_memread),
    .ex_memwrite    (ex_memwrite),
    .ex_memtoreg    (ex_memtoreg),
    .ex_size        (ex_size),
    .ex_unsigned    (ex_unsigned),
    .stall_out      (stall_out),
    .bus            (bus),
    .exmem_dest     (exmem_dest),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .wb_valid       (wb_valid),
    .wb_regwrite    (wb_regwrite),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .misalign       (misalign),
    .bus_err        (bus_err),
    .stall_cnt      (stall_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] link_pc;
    logic [4:0]  dest;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        m2r;
    logic        alink;
    logic        uns;
    logic [1:0]  sz;
  } op_t;

  int   checks;
  int   failures;
  int   m_stall_cnt;
  logic m_bus_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference load: shift the addressed lane down, mask to size, extend.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic uns);
    int          nbits;
    logic [31:0] v;
    logic [31:0] mask;
    nbits = 8 << sz;
    v = rd >> (8 * addr[1:0]);
    if (nbits < 32) begin
      mask = (32'h1 << nbits) - 32'h1;
      v = v & mask;
      if (!uns && v[nbits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] sz);
    int         nb;
    logic [7:0] m;
    nb = 1 << sz;
    m  = 8'((1 << nb) - 1) << addr[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
    if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic op_t new_op();
    op_t o;
    o.addr = 32'd0; o.sdata = 32'd0; o.rdata = 32'd0; o.link_pc = 32'd0;
    o.dest = 5'd0; o.rd = 1'b0; o.wr = 1'b0; o.rw = 1'b0; o.m2r = 1'b0;
    o.alink = 1'b0; o.uns = 1'b0; o.sz = SIZE_WORD;
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    ex_valid = 1'b1; ex_answer = o.addr; ex_store_data = o.sdata; ex_dest = o.dest;
    ex_alink = o.alink; ex_link_pc = o.link_pc; ex_regwrite = o.rw; ex_memread = o.rd;
    ex_memwrite = o.wr; ex_memtoreg = o.m2r; ex_size = o.sz; ex_unsigned = o.uns;
  endtask

  task automatic drive_bubble();
    ex_valid = 1'b0; ex_answer = 32'd0; ex_store_data = 32'd0; ex_dest = 5'd0;
    ex_alink = 1'b0; ex_link_pc = 32'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    ex_memwrite = 1'b0; ex_memtoreg = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
  endtask

  // One instruction through the stage; ack_lat = cycles until ack (-1 = never).
  task automatic run_op(input op_t o, input int ack_lat, input string tag);
    int          nb, cyc, stalls, exp_stall;
    logic        exp_mis, exp_req, aborted, done, exp_rw;
    logic [31:0] exp_data, c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    nb      = 1 << o.sz;
    exp_mis = (o.rd || o.wr) && ((o.addr % nb) != 0);
    exp_req = (o.rd || o.wr) && !exp_mis;
    aborted = exp_req && !(ack_lat >= 0 && ack_lat <= int'(TMO));
    exp_stall = !exp_req ? 0 : (aborted ? int'(TMO) : ack_lat);
    exp_rw  = o.rw && !exp_mis && !aborted;
    c_addr = 32'd0; c_wdata = 32'd0; c_be = 4'd0; c_we = 1'b0;

    @(negedge clk); drive_op(o);
    @(posedge clk);
    @(negedge clk); drive_bubble();
    cyc = 0; stalls = 0; done = 1'b0;
    while (!done && cyc < 300) begin
      bus.dm_ack   = exp_req && (ack_lat == cyc);
      bus.dm_rdata = o.rdata;
      #1;
      if (cyc == 0) begin
        checks++;
        if (bus.dm_req !== exp_req) begin
          failures++; $display("FAIL %s dm_req got %b want %b", tag, bus.dm_req, exp_req);
        end
        checks++;
        if (exmem_result !== (o.alink ? o.link_pc : o.addr)) begin
          failures++; $display("FAIL %s exmem_result got %h want %h", tag, exmem_result,
                               o.alink ? o.link_pc : o.addr);
        end
        checks++;
        if (exmem_regwrite !== (o.rw && !o.rd) || exmem_dest !== o.dest) begin
          failures++; $display("FAIL %s fwd rw/dest got %b/%0d want %b/%0d", tag, exmem_regwrite,
                               exmem_dest, o.rw && !o.rd, o.dest);
        end
        if (exp_req) begin
          checks++;
          if (bus.dm_addr !== (o.addr & 32'hFFFF_FFFC) || bus.dm_we !== o.wr) begin
            failures++; $display("FAIL %s dm_addr/we got %h/%b want %h/%b", tag, bus.dm_addr,
                                 bus.dm_we, o.addr & 32'hFFFF_FFFC, o.wr);
          end
          if (o.wr) begin
            checks++;
            if (bus.dm_be !== model_be(o.addr, o.sz) || bus.dm_wdata !== model_wdata(o.sdata, o.sz)) begin
              failures++; $display("FAIL %s be/wdata got %b/%h want %b/%h", tag, bus.dm_be,
                                   bus.dm_wdata, model_be(o.addr, o.sz), model_wdata(o.sdata, o.sz));
            end
          end
        end
        c_addr = bus.dm_addr; c_wdata = bus.dm_wdata; c_be = bus.dm_be; c_we = bus.dm_we;
      end else begin
        checks++;
        if (bus.dm_req !== 1'b1 || bus.dm_addr !== c_addr || bus.dm_wdata !== c_wdata ||
            bus.dm_be !== c_be || bus.dm_we !== c_we || wb_valid !== 1'b0) begin
          failures++; $display("FAIL %s hold cyc%0d got req=%b addr=%h be=%b wbv=%b want req=1 addr=%h be=%b wbv=0",
                               tag, cyc, bus.dm_req, bus.dm_addr, bus.dm_be, wb_valid, c_addr, c_be);
        end
      end
      if (stall_out) stalls++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); @(negedge clk);
      end
      cyc++;
    end
    checks++;
    if (!done || stalls != exp_stall) begin
      failures++; $display("FAIL %s stall cycles got %0d want %0d (done=%b)", tag, stalls, exp_stall, done);
    end

    @(posedge clk);
    @(negedge clk); bus.dm_ack = 1'b0;
    #1;
    m_stall_cnt += exp_stall;
    if (aborted) m_bus_err = 1'b1;
    checks++;
    if (wb_valid !== 1'b1 || wb_regwrite !== exp_rw || wb_dest !== o.dest) begin
      failures++; $display("FAIL %s wb v/rw/dest got %b/%b/%0d want 1/%b/%0d", tag, wb_valid,
                           wb_regwrite, wb_dest, exp_rw, o.dest);
    end
    if (o.alink || !o.m2r || (!exp_mis && !aborted)) begin
      exp_data = o.alink ? o.link_pc : (o.m2r ? model_load(o.rdata, o.addr, o.sz, o.uns) : o.addr);
      checks++;
      if (wb_data !== exp_data) begin
        failures++; $display("FAIL %s wb_data got %h want %h", tag, wb_data, exp_data);
      end
    end
    checks++;
    if (misalign !== exp_mis || stall_cnt !== 16'(m_stall_cnt) || bus_err !== m_bus_err) begin
      failures++; $display("FAIL %s mis/stall_cnt/bus_err got %b/%0d/%b want %b/%0d/%b", tag, misalign,
                           stall_cnt, bus_err, exp_mis, m_stall_cnt, m_bus_err);
    end
    checks++;
    if (bus.dm_req !== 1'b0 || stall_out !== 1'b0) begin
      failures++; $display("FAIL %s after req/stall got %b/%b want 0/0", tag, bus.dm_req, stall_out);
    end
  endtask

  task automatic test_reset();
    drive_bubble();
    bus.dm_ack = 1'b0; bus.dm_rdata = 32'd0;
    rst_n = 1'b0;
    m_stall_cnt = 0; m_bus_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.dm_req, bus.dm_we, bus.dm_addr, bus.dm_wdata, bus.dm_be, stall_out, exmem_dest,
         exmem_regwrite, exmem_result, wb_valid, wb_regwrite, wb_dest, wb_data, misalign,
         bus_err, stall_cnt} !== '0) begin
      failures++; $display("FAIL reset outputs got req=%b stall=%b wbv=%b wbd=%h cnt=%0d want all 0",
                           bus.dm_req, stall_out, wb_valid, wb_data, stall_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_word();
    op_t o;
    o = new_op(); o.addr = 32'h100; o.rd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.dest = 5'd4;
    o.rdata = 32'hDEADBEEF;
    run_op(o, 0, "lw_zero_wait");
  endtask

  task automatic test_load_byte();
    op_t o;
    o = new_op(); o.addr = 32'h103; o.rd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.dest = 5'd7;
    o.sz = SIZE_BYTE; o.rdata = 32'h80123456;
    run_op(o, 3, "lb_signed");
    o.uns = 1'b1;
    run_op(o, 3, "lbu");
  endtask

  task automatic test_store_half();
    op_t o;
    o = new_op(); o.addr = 32'h102; o.wr = 1'b1; o.sz = SIZE_HALF; o.sdata = 32'h1234ABCD;
    run_op(o, 1, "sh");
    o.addr = 32'h205; o.sz = SIZE_BYTE; o.sdata = 32'h000000A5;
    run_op(o, 0, "sb");
  endtask

  task automatic test_misaligned();
    op_t o;
    o = new_op(); o.addr = 32'h101; o.rd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.dest = 5'd9;
    run_op(o, 0, "lw_misaligned");
    o.addr = 32'h103; o.sz = SIZE_HALF;
    run_op(o, 0, "lh_misaligned");
  endtask

  task automatic test_timeout();
    op_t o;
    o = new_op(); o.addr = 32'h200; o.rd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.dest = 5'd3;
    o.rdata = 32'h0BADF00D;
    run_op(o, int'(TMO), "ack_at_limit");
    run_op(o, -1, "timeout_abort");
  endtask

  task automatic test_link();
    op_t o;
    o = new_op(); o.addr = 32'h1234; o.alink = 1'b1; o.link_pc = 32'h408; o.rw = 1'b1;
    o.dest = LINK_REG;
    run_op(o, 0, "jal");
  endtask

  task automatic test_back_to_back();
    op_t a, b;
    a = new_op(); a.addr = 32'h300; a.rd = 1'b1; a.m2r = 1'b1; a.rw = 1'b1; a.dest = 5'd1;
    a.rdata = 32'h11112222;
    b = a; b.addr = 32'h304; b.dest = 5'd2; b.rdata = 32'h33334444;
    @(negedge clk); drive_op(a);
    @(posedge clk);
    @(negedge clk); drive_op(b); bus.dm_ack = 1'b1; bus.dm_rdata = a.rdata;
    #1;
    checks++;
    if (bus.dm_addr !== a.addr || stall_out !== 1'b0) begin
      failures++; $display("FAIL b2b first addr/stall got %h/%b want %h/0", bus.dm_addr, stall_out, a.addr);
    end
    @(posedge clk);
    @(negedge clk); drive_bubble(); bus.dm_rdata = b.rdata;
    #1;
    checks++;
    if (bus.dm_addr !== b.addr || wb_data !== a.rdata || wb_dest !== a.dest) begin
      failures++; $display("FAIL b2b second addr/wb got %h/%h want %h/%h", bus.dm_addr, wb_data,
                           b.addr, a.rdata);
    end
    @(posedge clk);
    @(negedge clk); bus.dm_ack = 1'b0;
    #1;
    checks++;
    if (wb_data !== b.rdata || wb_regwrite !== 1'b1 || bus.dm_req !== 1'b0) begin
      failures++; $display("FAIL b2b final wb/rw/req got %h/%b/%b want %h/1/0", wb_data, wb_regwrite,
                           bus.dm_req, b.rdata);
    end
  endtask

  task automatic test_random();
    op_t o;
    int  kind, lat;
    for (int i = 0; i < 40; i++) begin
      o = new_op();
      kind = int'($urandom_range(0, 3));
      o.addr = $urandom; o.sdata = $urandom; o.rdata = $urandom; o.link_pc = $urandom;
      o.sz = 2'($urandom_range(0, 2)); o.uns = 1'($urandom_range(0, 1));
      o.dest = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 1) o.addr[1:0] = 2'b00;
      case (kind)
        0: begin o.rd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; end
        1: o.wr = 1'b1;
        2: o.rw = 1'($urandom_range(0, 1));
        default: begin o.alink = 1'b1; o.rw = 1'b1; o.dest = LINK_REG; end
      endcase
      lat = int'($urandom_range(0, 6));
      if (lat == 6) lat = -1;
      run_op(o, lat, "random");
    end
  endtask

  task automatic test_reset_in_wait();
    op_t o;
    o = new_op(); o.addr = 32'h400; o.rd = 1'b1; o.m2r = 1'b1; o.rw = 1'b1; o.dest = 5'd5;
    @(negedge clk); drive_op(o);
    @(posedge clk);
    @(negedge clk); drive_bubble(); bus.dm_ack = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b1 || bus.dm_req !== 1'b1) begin
      failures++; $display("FAIL rst_wait pre stall/req got %b/%b want 1/1", stall_out, bus.dm_req);
    end
    @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    m_stall_cnt = 0; m_bus_err = 1'b0;
    checks++;
    if (bus.dm_req !== 1'b0 || stall_out !== 1'b0 || bus.dm_be !== 4'd0 || wb_valid !== 1'b0 ||
        stall_cnt !== 16'd0 || bus_err !== 1'b0 || exmem_result !== 32'd0) begin
      failures++; $display("FAIL rst_wait got req=%b stall=%b be=%b wbv=%b cnt=%0d err=%b want all 0",
                           bus.dm_req, stall_out, bus.dm_be, wb_valid, stall_cnt, bus_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.dm_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL rst_wait after got req=%b stall=%b wbv=%b want 0/0/0", bus.dm_req,
                           stall_out, wb_valid);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_link();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
